nibble_serial_add16: RTL and testbench
======================================

# nibble_serial_add16

Sequential controller that performs a 16-bit (parameterisable) addition by time-multiplexing one external 4-bit ripple-carry adder slice over NIBBLES clock cycles. It sits directly around the 4-bit slice: it feeds the slice its operand nibbles and carry-in, then consumes the slice's sum and carry-out. It is the area-reduced alternative to the chained 16-bit adder on the DE2 datapath. The result is returned through a start/busy/done handshake.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  W  operand A; captured on an accepted start.
- b_in  in  W  operand B; captured on an accepted start.
- c_in  in  1  carry into nibble 0; captured on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  result; updated only when done rises.
- c_out  out  1  carry out of the top nibble.
- overflow  out  1  two's-complement overflow of A+B+c_in.
- slice_a  out  4  operand A nibble to the external slice.
- slice_b  out  4  operand B nibble to the external slice.
- slice_cin  out  1  carry into the external slice.
- slice_sum  in  4  sum from the external slice; combinational from slice_a, slice_b and slice_cin.
- slice_cout  in  1  carry from the external slice.

## Operation
- Registers:
  - a_reg, b_reg (W bits each).
  - carry_reg.
  - idx (ceil(log2 NIBBLES) bits, min 1).
  - work (W-bit partial sum).
  - state: IDLE or RUN.
  - Output registers: sum, c_out, overflow, done.
- IDLE, start=1:
  - a_reg<=a_in, b_reg<=b_in, carry_reg<=c_in, idx<=0, state<=RUN.
- IDLE, start=0: all registers hold.
- RUN, combinational slice drive:
  - slice_a = a_reg[4*idx+:4].
  - slice_b = b_reg[4*idx+:4].
  - slice_cin = carry_reg.
- RUN, on each edge:
  - work[4*idx+:4] <= slice_sum.
  - carry_reg <= slice_cout.
  - idx <= idx+1.
- RUN, last edge (idx == NIBBLES-1):
  - sum <= {slice_sum, work[W-5:0]}.
  - c_out <= slice_cout.
  - overflow <= (a_reg[W-1]==b_reg[W-1]) && (slice_sum[3]!=a_reg[W-1]).
  - done <= 1.
  - state <= IDLE.
- In IDLE, slice_a, slice_b and slice_cin are driven 0.
- done is cleared on every edge where it was not just set.
- start while busy is ignored. a_in, b_in and c_in changing during RUN have no effect.
- sum, c_out and overflow hold their last result until the next completion. They never show partial nibbles.

## Timing
- Reset, while rst=1 at an edge:
  - state=IDLE, idx=0, carry_reg=0.
  - a_reg, b_reg, work, sum, c_out, overflow, done, busy all 0.
  - Slice outputs 0.
  - rst has priority over start.
- Reset mid-RUN: the operation aborts, no done pulse is issued, and results read 0.
- Latency:
  - start sampled at edge E0.
  - Nibbles are captured at E1..E(NIBBLES).
  - done, sum, c_out and overflow are valid from E(NIBBLES) to E(NIBBLES+1) (done); the results persist after that.
- busy is high from E0 until E(NIBBLES). It is low in the done cycle.
- Back-to-back: start sampled in the done cycle is accepted. Throughput is one operation per NIBBLES+1 cycles.
- The slice path (slice_a → slice_sum → work) is a single-cycle combinational path inside one clock period. There is no multicycle constraint.
- Carry wrap: there is no wrap. idx never exceeds NIBBLES-1, and the final carry goes only to c_out.

## Test plan
- 0x1234 + 0x4321, c_in=0, start pulsed at E0:
  - sum=0x5555, c_out=0, overflow=0.
  - done high exactly between E4 and E5; busy high E0–E4.
- 0xFFFF + 0x0001, c_in=0: sum=0x0000, c_out=1, overflow=0.
- Signed overflow and carry-in:
  - 0x7FFF + 0x0001, c_in=0: sum=0x8000, c_out=0, overflow=1.
  - 0x00FF + 0x0000, c_in=1: sum=0x0100, c_out=0.
- Slice sequencing for 0xABCD + 0x1111, c_in=0:
  - slice_a = D, C, B, A.
  - slice_b = 1, 1, 1, 1.
  - slice_cin = 0, 0, 0, 0.
  - Final sum=0xBCDE.
  - Slice outputs are 0 in IDLE.
- start held high with a_in changing every cycle:
  - done pulses every 5 cycles.
  - Each result matches the operands present at its accepting edge.
  - Changes to a_in during RUN are ignored.
- rst=1 at E2 of 0x1234 + 0x4321:
  - No done pulse; sum=0, busy=0 after the edge.
  - A following start of 0x0002 + 0x0003 yields sum=0x0005 after 4 cycles.

Source files
------------

// File: rtl/nibble_serial_add16.sv
// ============================================================================
// Module   : nibble_serial_add16
// Brief    : W-bit adder built by stepping one external 4-bit ripple-carry
//            slice across the operands, one nibble per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_add16 #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic                   overflow,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic                   slice_cin,
    input  logic [3:0]             slice_sum,
    input  logic                   slice_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_work;
    logic [W-1:0]     r_sum;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_done;

    logic             w_run;
    logic             w_last;
    logic [IDX_W+1:0] w_base;
    logic [W-1:0]     w_final;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_base = {r_idx, 2'b00};

    // Final result: accumulated lower nibbles with the top nibble taken live
    // from the slice, so the completed sum is published on the last edge.
    always_comb begin
        w_final           = r_work;
        w_final[W-4 +: 4] = slice_sum;
    end

    assign slice_a   = w_run ? r_a[w_base +: 4] : 4'h0;
    assign slice_b   = w_run ? r_b[w_base +: 4] : 4'h0;
    assign slice_cin = w_run ? r_carry : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_work     <= '0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_work[w_base +: 4] <= slice_sum;
                    r_carry             <= slice_cout;
                    if (w_last) begin
                        r_idx      <= '0;
                        r_sum      <= w_final;
                        r_c_out    <= slice_cout;
                        r_overflow <= (r_a[W-1] == r_b[W-1]) &&
                                      (slice_sum[3] != r_a[W-1]);
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = w_run;
    assign done     = r_done;
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add16.sv
// ============================================================================
// Module   : tb_nibble_serial_add16
// Brief    : Directed vectors against a behavioural 4-bit slice; results are
//            checked by a done-driven monitor popping an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_add16;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic         slice_cin;
    logic [3:0]   slice_sum;
    logic         slice_cout;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // External 4-bit ripple-carry slice
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    nibble_serial_add16 #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .c_out      (c_out),
        .overflow   (overflow),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no result at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("c_out", 32'(c_out), 32'(e.co));
                check("overflow", 32'(overflow), 32'(e.ov));
            end
        end
    end

    // Issue one operation from just after an edge; returns just after the
    // edge on which done rises, ready for a back-to-back start.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic eco, input logic eov);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        q.push_back('{s: es, co: eco, ov: eov});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (NIBBLES) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] acc [3];
        logic [3:0]   exp_a [4];
        acc[0] = 16'h0001;
        acc[1] = 16'h2222;
        acc[2] = 16'hF000;
        exp_a[0] = 4'hD;
        exp_a[1] = 4'hC;
        exp_a[2] = 4'hB;
        exp_a[3] = 4'hA;

        rst = 1'b1; start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        // First vector with cycle-exact busy/done checks
        start = 1'b1; a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b0;
        q.push_back('{s: 16'h5555, co: 1'b0, ov: 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < NIBBLES; e++) begin
            check("lat_busy", 32'(busy), 32'd1);
            check("lat_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        check("done_busy", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_clear", 32'(done), 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Slice sequencing
        check("idle_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        start = 1'b1; a_in = 16'hABCD; b_in = 16'h1111; c_in = 1'b0;
        q.push_back('{s: 16'hBCDE, co: 1'b0, ov: 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < NIBBLES; e++) begin
            check("slice_a", 32'(slice_a), 32'(exp_a[e]));
            check("slice_b", 32'(slice_b), 32'h1);
            check("slice_cin", 32'(slice_cin), 32'h0);
            @(posedge clk); #1;
        end
        check("idle_slice_after", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        @(posedge clk); #1;

        // start held high, a_in changing every cycle
        start = 1'b1; b_in = 16'h1000; c_in = 1'b0; a_in = acc[0];
        for (int t = 0; t < 15; t++) begin
            if (t % 5 == 0)
                q.push_back('{s: acc[t/5] + 16'h1000, co: (t == 10), ov: 1'b0});
            @(posedge clk); #1;
            check("held_done", 32'(done), 32'(t % 5 == 4));
            a_in = ((t + 1) % 5 == 0 && t < 14) ? acc[(t+1)/5] : (16'hDEAD ^ 16'(t));
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Reset mid-run aborts without a done pulse
        start = 1'b1; a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        run_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);
        @(posedge clk); #1;

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
